// File: rtl/comma_aligner_pkg.sv
// Shared K28.5 comma constants, aligner states and saturating helpers.
// Imported by the comma aligner and its comma detector.
package comma_aligner_pkg;

  localparam logic [9:0] K28_5_RDN = 10'b0011111010;
  localparam logic [9:0] K28_5_RDP = 10'b1100000101;

  localparam int unsigned LOCK_CNT_DEF = 3;
  localparam int unsigned MISS_MAX_DEF = 2;
  localparam int unsigned ERR_MAX_DEF  = 4;

  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_CHECK  = 2'd1,
    ST_LOCKED = 2'd2
  } alignSt_t;

  function automatic logic [1:0] satInc2(input logic [1:0] v);
    return (v == 2'd3) ? v : v + 2'd1;
  endfunction

  function automatic logic [2:0] satInc3(input logic [2:0] v);
    return (v == 3'd7) ? v : v + 3'd1;
  endfunction

endpackage

// File: rtl/comma_aligner_detect.sv
// Combinational K28.5 detector over a 10-bit window, either disparity.
// Kept separate so lane-alignment logic can reuse it.
module comma_detect
  import comma_aligner_pkg::*;
#(
  parameter logic [9:0] COMMA_P = K28_5_RDN,
  parameter logic [9:0] COMMA_N = K28_5_RDP
) (
  input  logic [9:0] word,
  output logic       hit
);

  assign hit = (word == COMMA_P) | (word == COMMA_N);

endmodule

// File: rtl/comma_aligner.sv
// Serial-to-parallel word aligner ahead of the 8b/10b decoder.
// Hunts for K28.5, fixes the word boundary, tracks lock quality.
module comma_aligner
  import comma_aligner_pkg::*;
#(
  parameter logic [9:0]  COMMA_P  = K28_5_RDN,
  parameter logic [9:0]  COMMA_N  = K28_5_RDP,
  parameter int unsigned LOCK_CNT = LOCK_CNT_DEF,
  parameter int unsigned MISS_MAX = MISS_MAX_DEF,
  parameter int unsigned ERR_MAX  = ERR_MAX_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enb,
  input  logic       serial_in,
  input  logic       code_err,
  output logic [9:0] data10_out,
  output logic       valid,
  output logic       locked
);

  localparam logic [1:0] lockW = 2'(LOCK_CNT);
  localparam logic [1:0] missW = 2'(MISS_MAX);
  localparam logic [2:0] errW  = 3'(ERR_MAX);

  logic [9:0] sr;
  logic [9:0] srD;
  logic [3:0] bitCnt;
  alignSt_t   state;
  logic [1:0] commaCnt;
  logic [1:0] missCnt;
  logic [2:0] errCnt;
  logic       hit;
  logic       bnd;
  logic [1:0] commaInc;
  logic [1:0] missNx;
  logic [2:0] errNx;
  logic       lossNow;

  assign srD      = {sr[8:0], serial_in};
  assign bnd      = (bitCnt == 4'd9);
  assign commaInc = satInc2(commaCnt);

  comma_detect #(
    .COMMA_P(COMMA_P),
    .COMMA_N(COMMA_N)
  ) uDetect (
    .word(srD),
    .hit (hit)
  );

  // Lock-quality counters as they would be after this edge in LOCKED
  always_comb begin
    missNx = missCnt;
    errNx  = errCnt;
    if (hit && bnd) begin
      missNx = 2'd0;
    end else if (hit) begin
      missNx = satInc2(missCnt);
    end
    if (bnd) begin
      errNx = code_err ? satInc3(errCnt) : 3'd0;
    end
    lossNow = (missNx >= missW) || (errNx >= errW);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sr         <= '0;
      bitCnt     <= '0;
      state      <= ST_HUNT;
      commaCnt   <= '0;
      missCnt    <= '0;
      errCnt     <= '0;
      data10_out <= '0;
      valid      <= 1'b0;
      locked     <= 1'b0;
    end else if (!enb) begin
      valid <= 1'b0;
    end else begin
      sr     <= srD;
      valid  <= 1'b0;
      bitCnt <= bnd ? 4'd0 : bitCnt + 4'd1;
      unique case (state)
        ST_HUNT: begin
          if (hit) begin
            data10_out <= srD;
            valid      <= 1'b1;
            bitCnt     <= 4'd0;
            commaCnt   <= 2'd1;
            state      <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          if (bnd) begin
            data10_out <= srD;
            valid      <= 1'b1;
            if (hit) begin
              commaCnt <= commaInc;
              if (commaInc == lockW) begin
                state   <= ST_LOCKED;
                locked  <= 1'b1;
                missCnt <= 2'd0;
                errCnt  <= 3'd0;
              end
            end
          end else if (hit) begin
            data10_out <= srD;
            valid      <= 1'b1;
            bitCnt     <= 4'd0;
            commaCnt   <= 2'd1;
          end
        end
        ST_LOCKED: begin
          if (bnd) begin
            data10_out <= srD;
            valid      <= 1'b1;
          end
          if (lossNow) begin
            state    <= ST_HUNT;
            locked   <= 1'b0;
            commaCnt <= 2'd0;
            missCnt  <= 2'd0;
            errCnt   <= 3'd0;
          end else begin
            missCnt <= missNx;
            errCnt  <= errNx;
          end
        end
        default: begin
          state  <= ST_HUNT;
          locked <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_comma_aligner.sv
// Directed bench for comma_aligner with a word scoreboard.
// Expected words come from the bench's own bit history and phase.
module tb_comma_aligner;
  import comma_aligner_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       enb = 1'b1;
  logic       serialIn = 1'b0;
  logic       codeErr = 1'b0;
  logic [9:0] data10;
  logic       valid;
  logic       locked;

  int tests = 0;
  int fails = 0;

  logic [9:0] expQ[$];
  logic [9:0] hist = '0;
  logic [9:0] lastWord = '0;
  bit         tbAligned = 1'b0;
  int         pos = 0;

  localparam logic [9:0] D00  = 10'b1001110100;
  localparam logic [9:0] D215 = 10'b1010101010;

  always #5 clk = ~clk;

  comma_aligner dut (
    .clk       (clk),
    .rst       (rst),
    .enb       (enb),
    .serial_in (serialIn),
    .code_err  (codeErr),
    .data10_out(data10),
    .valid     (valid),
    .locked    (locked)
  );

  task automatic chk(string tag, logic [9:0] got, logic [9:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %b want %b", tag, got, exp);
    end
  endtask

  task automatic chkB(string tag, logic got, logic exp);
    chk(tag, {9'b0, got}, {9'b0, exp});
  endtask

  task automatic pushWord(logic [9:0] w);
    expQ.push_back(w);
    lastWord = w;
  endtask

  task automatic sendBit(logic b);
    serialIn = b;
    @(posedge clk);
    #1;
    hist = {hist[8:0], b};
    if (tbAligned) begin
      pos++;
      if (pos == 10) begin
        pos = 0;
        pushWord(hist);
      end
    end
  endtask

  task automatic sendWord(logic [9:0] w);
    for (int i = 9; i >= 0; i--) sendBit(w[i]);
  endtask

  task automatic sendBits(logic [9:0] v, int n);
    for (int i = n - 1; i >= 0; i--) sendBit(v[i]);
  endtask

  // Comma that sets a new word phase (hunt hit or realign)
  task automatic newPhaseComma(logic [9:0] w);
    sendWord(w);
    pushWord(hist);
    tbAligned = 1'b1;
    pos = 0;
  endtask

  task automatic errWord(logic [9:0] w, logic e);
    codeErr = e;
    sendWord(w);
    codeErr = 1'b0;
  endtask

  always @(negedge clk) begin
    if (rst && valid) begin
      tests++;
      assert (expQ.size() > 0) else begin
        fails++;
        $error("FAIL spurious_word: got %b want none", data10);
      end
      if (expQ.size() > 0) chk("word", data10, expQ.pop_front());
    end
  end

  initial begin
    // reset held while the line toggles
    for (int i = 0; i < 6; i++) begin
      serialIn = i[0];
      @(posedge clk);
      #1;
      chk("rst_data", data10, 10'd0);
      chkB("rst_valid", valid, 1'b0);
      chkB("rst_locked", locked, 1'b0);
    end
    rst = 1'b1;
    hist = '0;

    // acquire
    sendBits(10'b101, 3);
    newPhaseComma(K28_5_RDN);
    chkB("acq_lock1", locked, 1'b0);
    sendWord(D00);
    sendWord(K28_5_RDP);
    chkB("acq_lock2", locked, 1'b0);
    sendWord(D215);
    sendWord(K28_5_RDN);
    chkB("acq_lock3", locked, 1'b1);

    // misaligned commas while locked
    sendWord(D215);
    sendBits(10'b1010, 4);
    sendWord(K28_5_RDN);
    chkB("miss1_keeps", locked, 1'b1);
    sendWord(D215);
    chkB("miss1_still", locked, 1'b1);
    sendWord(K28_5_RDP);
    chkB("miss2_loss", locked, 1'b0);
    tbAligned = 1'b0;

    // realign in CHECK after a one-bit slip
    newPhaseComma(K28_5_RDN);
    sendWord(D00);
    sendBits(10'b1, 1);
    newPhaseComma(K28_5_RDP);
    chkB("realign_lock0", locked, 1'b0);
    sendWord(D215);
    sendWord(K28_5_RDN);
    chkB("realign_lock1", locked, 1'b0);
    sendWord(D00);
    sendWord(K28_5_RDP);
    chkB("realign_lock2", locked, 1'b1);

    // decoder error runs
    for (int i = 0; i < 3; i++) errWord(D215, 1'b1);
    errWord(D00, 1'b0);
    for (int i = 0; i < 3; i++) errWord(D215, 1'b1);
    chkB("err_313_keeps", locked, 1'b1);
    errWord(D00, 1'b0);
    for (int i = 0; i < 3; i++) errWord(D215, 1'b1);
    chkB("err3_keeps", locked, 1'b1);
    errWord(D215, 1'b1);
    chkB("err4_loss", locked, 1'b0);
    tbAligned = 1'b0;

    // reacquire
    newPhaseComma(K28_5_RDN);
    sendWord(D00);
    sendWord(K28_5_RDP);
    sendWord(D215);
    sendWord(K28_5_RDN);
    chkB("reacq_lock", locked, 1'b1);

    // enable stall mid-word
    for (int i = 9; i >= 5; i--) sendBit(D00[i]);
    enb = 1'b0;
    for (int i = 0; i < 7; i++) begin
      serialIn = ~serialIn;
      @(posedge clk);
      #1;
      chkB("stall_valid", valid, 1'b0);
      chk("stall_data", data10, lastWord);
    end
    enb = 1'b1;
    for (int i = 4; i >= 0; i--) sendBit(D00[i]);
    chkB("stall_lock", locked, 1'b1);
    sendWord(K28_5_RDP);
    chkB("stall_lock2", locked, 1'b1);

    // async reset between edges, mid-word
    for (int i = 9; i >= 5; i--) sendBit(D215[i]);
    #2 rst = 1'b0;
    #1;
    chk("arst_data", data10, 10'd0);
    chkB("arst_valid", valid, 1'b0);
    chkB("arst_locked", locked, 1'b0);
    #3 rst = 1'b1;
    hist = '0;
    tbAligned = 1'b0;
    pos = 0;
    lastWord = '0;

    newPhaseComma(K28_5_RDP);
    sendWord(D215);
    sendWord(K28_5_RDN);
    chkB("post_rst_lock0", locked, 1'b0);
    sendWord(D00);
    sendWord(K28_5_RDP);
    chkB("post_rst_lock1", locked, 1'b1);
    sendWord(D215);
    repeat (3) @(posedge clk);
    #1;

    tests++;
    assert (expQ.size() == 0) else begin
      fails++;
      $error("FAIL missing_words: got %0d pending want 0", expQ.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
